// File: rtl/rom_arb_pkg.sv
// Shared constants, the request-ID width helper and the read-pipeline entry type
// used by the round-robin ROM arbiter.
package rom_arb_pkg;

  localparam int ROM_ADDR_W      = 5;
  localparam int ROM_DATA_W      = 8;
  localparam int ROM_ARB_NUM_REQ = 4;
  localparam int CNT_W           = 16;

  // The pipeline ID field is sized for the largest supported requester count (8).
  localparam int PIPE_ID_W = 3;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [PIPE_ID_W-1:0] id;
  } pipe_ent_t;

endpackage

// File: rtl/rom_rr_arbiter_rr_grant.sv
// Round-robin priority picker: the search starts one past ptr and wraps, and the
// first asserted request wins. Purely combinational.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == ID_W'(NUM_REQ - 1)) idx = '0;
      else                           idx = idx + ID_W'(1);
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM between NUM_REQ requesters.
// Optional grant counters are built when ROM_ARB_STATS_EN is defined.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = rom_arb_pkg::ROM_ARB_NUM_REQ,
  parameter int ADDR_W  = rom_arb_pkg::ROM_ADDR_W,
  parameter int DATA_W  = rom_arb_pkg::ROM_DATA_W,
  parameter int CNT_W   = rom_arb_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [id_w(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rom_rd,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       busy,
  input  logic                       stats_clr,
  output logic [NUM_REQ*CNT_W-1:0]   grant_cnt
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [ID_W-1:0]    ptr;
  logic [ADDR_W-1:0]  win_addr;
  pipe_ent_t          pipe_p1;
  pipe_ent_t          pipe_p2;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_grant (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign win_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign req_ready = gnt;

  // p1: request issued to the ROM; p2: ROM output register loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      pipe_p1  <= '0;
      pipe_p2  <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      rom_rd        <= gnt_any;
      pipe_p1.valid <= gnt_any;
      pipe_p1.id    <= PIPE_ID_W'(gnt_idx);
      pipe_p2       <= pipe_p1;
      if (gnt_any) begin
        rom_addr <= win_addr;
        ptr      <= gnt_idx;
      end
    end
  end

  assign rsp_valid = pipe_p2.valid;
  assign rsp_id    = pipe_p2.id[ID_W-1:0];
  assign rsp_data  = rom_data;
  assign busy      = pipe_p1.valid | pipe_p2.valid;

`ifdef ROM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  // Clear dominates a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign grant_cnt        = '0;
`endif

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
Round-robin arbiter and read sequencer that shares one 32x8 registered-output ROM between NUM_REQ requesters. It accepts per-requester valid/ready read requests and drives the ROM rd/addr pins from registers. It tracks the ROM's one-cycle registered read latency in a 2-stage tag pipeline and returns tagged responses. It sits between client blocks and the ROM, which is the arbiter's only ROM master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, ROM address width (32 locations)
DATA_W, 8, ROM data width
CNT_W, 16, grant-counter width (only used with ROM_ARB_STATS_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready at a clk edge
rsp_valid  out  1  response strobe, one cycle, no backpressure
rsp_id  out  clog2(NUM_REQ)  requester index of the response
rsp_data  out  DATA_W  read data; passthrough of rom_data
rom_rd  out  1  ROM rd, registered
rom_addr  out  ADDR_W  ROM addr, registered
rom_data  in  DATA_W  ROM registered output
busy  out  1  high when the pipeline holds a request (s1_valid|s2_valid)
stats_clr  in  1  synchronous clear of the grant counters
grant_cnt  out  NUM_REQ*CNT_W  per-requester grant counters

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rom_rd=0, rom_addr=0, busy=0, RR pointer=NUM_REQ-1 (requester 0 has top priority first), all counters 0. rsp_data follows rom_data, which the ROM resets to 0.
- Arbitration (combinational, cycle T): search starts at ptr+1 and wraps modulo NUM_REQ. The first asserted req_valid wins and gets req_ready. If no req_valid is asserted, req_ready=0. There is no dependence on downstream state; a grant is possible every cycle.
- Issue, edge ending T on a grant: rom_rd<=1, rom_addr<=winner's addr, s1_valid<=1, s1_id<=winner, ptr<=winner. With no grant: rom_rd<=0, s1_valid<=0, rom_addr holds, ptr holds.
- Edge ending T+1: the ROM loads its output; s2_valid<=s1_valid, s2_id<=s1_id.
- Cycle T+2: rsp_valid=s2_valid, rsp_id=s2_id, rsp_data=rom_data. Latency from handshake cycle to response cycle is exactly 2. Throughput is 1 request per cycle.
- Back-to-back grants pipeline: responses come out in grant order, one per cycle, with no bubbles.
- rom_data is undefined whenever rsp_valid=0, because ROM rd is low. The bench must not check rsp_data then.
- A requester that drops req_valid before its grant is simply skipped.
- The same requester holding valid is re-granted only after every other active requester has been served (fairness bound NUM_REQ-1 cycles).
- Reset mid-operation: the in-flight s1/s2 entries are discarded and no rsp_valid is produced for them. Arbitration restarts from requester 0.

Optional Feature:
ROM_ARB_STATS_EN
- Defined: per-requester CNT_W counters increment on each handshake and saturate at all-ones. stats_clr zeroes all counters; if stats_clr and a grant occur in the same cycle, the result is 0.
- Undefined: grant_cnt is tied to 0, stats_clr is ignored, and the ports stay present so the interface is stable.

Decomposition:
- Package rom_arb_pkg holds:
  - constants ROM_ADDR_W=5, ROM_DATA_W=8, ROM_ARB_NUM_REQ=4, CNT_W=16;
  - function for ID width (clog2);
  - typedef of the pipeline entry struct {valid, id}.
- Sub-module rr_grant: pure round-robin priority picker with inputs req vector and ptr, output one-hot grant plus index. Instantiated once.

Test Plan:
1. Single request: requester 0 addr=0 for 1 cycle -> req_ready[0] same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=0x45.
2. All 4 requesters valid continuously, addrs 5/13/31/2 -> grants 0,1,2,3,0... on consecutive cycles; rsp sequence 0xab,0xe4,0xc3,0x23 with ids 0..3, no gaps.
3. Requesters 1 and 3 valid, ptr=1 -> grant 3, then 1, alternating; requester 1 is never granted twice in a row.
4. Grant to requester 2 (addr 9), assert rst the cycle after -> no rsp_valid ever for it. After release, rom_rd=0 and the next grant goes to requester 0 first.
5. Sweep addr 0..31 from requester 1 -> 32 responses matching the ROM table (e.g. 19->0x0a, 25->0xda), each exactly 2 cycles after its handshake.
6. Stats (macro on): 70000 grants to requester 0 -> grant_cnt[0]=0xFFFF. stats_clr together with a grant -> 0.
